// File: rtl/fft_input_loader_if.sv
// Sample-stream and RAM-write bundle between upstream source, the FFT input
// loader and the sample RAM.
interface fft_input_loader_if #(
    parameter int N = 8,
    parameter int I = 4,
    parameter int F = 4
);
    localparam int AW = $clog2(N);
    localparam int DW = I + F;

    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_frame_done;
    logic          i_frame_ack;
    logic [AW-1:0] o_count;

    modport slave (
        input  i_valid, i_data, i_frame_ack,
        output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_count
    );

    modport master (
        output i_valid, i_data, i_frame_ack,
        input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_frame_done, o_count
    );
endinterface

// File: rtl/fft_input_loader.sv
// Loads one frame of N samples into the sample RAM in bit-reversed (or natural)
// address order, then holds the frame until the consumer acknowledges it.
module fft_input_loader #(
    parameter int N      = 8,
    parameter int I      = 4,
    parameter int F      = 4,
    parameter int BITREV = 1
) (
    input  logic               clk,
    input  logic               rst,
    fft_input_loader_if.slave  bus
);
    localparam int AW = $clog2(N);
    localparam int DW = I + F;

    typedef enum logic {LOAD, FULL} state_t;

    state_t        state, state_next;
    logic [AW-1:0] count, count_next;
    logic [AW-1:0] addr, addr_next;
    logic [DW-1:0] data, data_next;
    logic          ready, ready_next;
    logic          wr_en, wr_en_next;
    logic          done, done_next;
    logic          accept;

    function automatic logic [AW-1:0] rev(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = k[AW-1-b];
        end
        return r;
    endfunction

    assign accept = bus.i_valid & ready;

    always_comb begin
        state_next = state;
        count_next = count;
        addr_next  = addr;
        data_next  = data;
        ready_next = ready;
        wr_en_next = 1'b0;
        done_next  = 1'b0;
        case (state)
            LOAD: begin
                ready_next = 1'b1;
                if (accept) begin
                    wr_en_next = 1'b1;
                    data_next  = bus.i_data;
                    addr_next  = (BITREV != 0) ? rev(count) : count;
                    if (count == AW'(N - 1)) begin
                        count_next = '0;
                        ready_next = 1'b0;
                        done_next  = 1'b1;
                        state_next = FULL;
                    end else begin
                        count_next = count + AW'(1);
                    end
                end
            end
            FULL: begin
                ready_next = 1'b0;
                if (bus.i_frame_ack) begin
                    ready_next = 1'b1;
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
                count_next = '0;
                ready_next = 1'b0;
            end
        endcase
    end

    // o_ready starts low out of reset and rises on the first clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            count <= '0;
            addr  <= '0;
            data  <= '0;
            ready <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            addr  <= addr_next;
            data  <= data_next;
            ready <= ready_next;
            wr_en <= wr_en_next;
            done  <= done_next;
        end
    end

    assign bus.o_ready      = ready;
    assign bus.o_wr_en      = wr_en;
    assign bus.o_wr_addr    = addr;
    assign bus.o_wr_data    = data;
    assign bus.o_frame_done = done;
    assign bus.o_count      = count;
endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench: a bit-reversing and a natural-order loader share one
// stimulus stream; expected RAM writes are queued on accept and checked on write.
module tb_fft_input_loader;
    localparam int N = 8;
    localparam int I = 4;
    localparam int F = 4;

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [2:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       done;
    } wr_t;

    logic clk;
    logic rst;

    fft_input_loader_if #(.N(N), .I(I), .F(F)) bus_rev ();
    fft_input_loader_if #(.N(N), .I(I), .F(F)) bus_nat ();

    assign bus_nat.i_valid     = bus_rev.i_valid;
    assign bus_nat.i_data      = bus_rev.i_data;
    assign bus_nat.i_frame_ack = bus_rev.i_frame_ack;

    fft_input_loader #(.N(N), .I(I), .F(F), .BITREV(1)) dut_rev (
        .clk (clk),
        .rst (rst),
        .bus (bus_rev)
    );

    fft_input_loader #(.N(N), .I(I), .F(F), .BITREV(0)) dut_nat (
        .clk (clk),
        .rst (rst),
        .bus (bus_nat)
    );

    vec_t vecs [8];
    wr_t  q_rev [$];
    wr_t  q_nat [$];
    int   tests_run  = 0;
    int   tests_fail = 0;
    int   done_seen  = 0;
    int   frames_exp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Write monitor: every RAM write strobe must match the oldest queued accept.
    always @(negedge clk) begin
        wr_t e;
        if (bus_rev.o_frame_done) done_seen++;
        if (bus_rev.o_frame_done && !bus_rev.o_wr_en)
            check_output("done_without_write", 32'(bus_rev.o_wr_en), 32'd1);
        if (bus_rev.o_wr_en) begin
            if (q_rev.size() == 0) begin
                check_output("rev_unexpected_write", 32'(bus_rev.o_wr_addr), 32'hFFFF);
            end else begin
                e = q_rev.pop_front();
                check_output("rev_addr", 32'(bus_rev.o_wr_addr), 32'(e.addr));
                check_output("rev_data", 32'(bus_rev.o_wr_data), 32'(e.data));
                check_output("rev_done", 32'(bus_rev.o_frame_done), 32'(e.done));
            end
        end
        if (bus_nat.o_wr_en) begin
            if (q_nat.size() == 0) begin
                check_output("nat_unexpected_write", 32'(bus_nat.o_wr_addr), 32'hFFFF);
            end else begin
                e = q_nat.pop_front();
                check_output("nat_addr", 32'(bus_nat.o_wr_addr), 32'(e.addr));
                check_output("nat_data", 32'(bus_nat.o_wr_data), 32'(e.data));
                check_output("nat_done", 32'(bus_nat.o_frame_done), 32'(e.done));
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic apply_stimulus(input int i, input bit use_gaps);
        bit   accepted = 1'b0;
        logic rdy;
        wr_t  e;
        if (use_gaps) repeat (vecs[i].gap) @(negedge clk);
        for (int t = 0; t < 20 && !accepted; t++) begin
            bus_rev.i_valid = 1'b1;
            bus_rev.i_data  = vecs[i].data;
            rdy = bus_rev.o_ready;
            @(posedge clk);
            if (rdy) begin
                accepted = 1'b1;
                e.addr = vecs[i].exp_addr;
                e.data = vecs[i].data;
                e.done = (i == N - 1);
                q_rev.push_back(e);
                e.addr = i[2:0];
                q_nat.push_back(e);
            end
            @(negedge clk);
            bus_rev.i_valid = 1'b0;
        end
        if (accepted) begin
            check_output("wr_latency", 32'(bus_rev.o_wr_en), 32'd1);
            check_output("count", 32'(bus_rev.o_count), 32'((i + 1) % N));
        end else begin
            check_output("accept_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic pulse_ack();
        bus_rev.i_frame_ack = 1'b1;
        @(negedge clk);
        bus_rev.i_frame_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_ready"}, 32'(bus_rev.o_ready), 32'd0);
        check_output({tag, "_wr_en"}, 32'(bus_rev.o_wr_en), 32'd0);
        check_output({tag, "_wr_addr"}, 32'(bus_rev.o_wr_addr), 32'd0);
        check_output({tag, "_wr_data"}, 32'(bus_rev.o_wr_data), 32'd0);
        check_output({tag, "_done"}, 32'(bus_rev.o_frame_done), 32'd0);
        check_output({tag, "_count"}, 32'(bus_rev.o_count), 32'd0);
        check_output({tag, "_nat_count"}, 32'(bus_nat.o_count), 32'd0);
    endtask

    initial begin
        vecs[0] = '{8'h10, 0, 3'd0};
        vecs[1] = '{8'h11, 1, 3'd4};
        vecs[2] = '{8'h12, 2, 3'd2};
        vecs[3] = '{8'h13, 0, 3'd6};
        vecs[4] = '{8'h14, 0, 3'd1};
        vecs[5] = '{8'h15, 1, 3'd5};
        vecs[6] = '{8'h16, 3, 3'd3};
        vecs[7] = '{8'h17, 0, 3'd7};

        rst = 1'b0;
        bus_rev.i_valid     = 1'b0;
        bus_rev.i_data      = '0;
        bus_rev.i_frame_ack = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;
        check_output("ready_before_edge", 32'(bus_rev.o_ready), 32'd0);
        @(negedge clk);
        check_output("ready_after_edge", 32'(bus_rev.o_ready), 32'd1);

        // Back-to-back frame.
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0);
        frames_exp++;
        check_output("ready_full", 32'(bus_rev.o_ready), 32'd0);

        // Held valid while full and unacknowledged.
        bus_rev.i_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check_output("hold_ready", 32'(bus_rev.o_ready), 32'd0);
            check_output("hold_wr_en", 32'(bus_rev.o_wr_en), 32'd0);
            check_output("hold_count", 32'(bus_rev.o_count), 32'd0);
        end
        bus_rev.i_valid = 1'b0;
        check_output("done_pulses_1", 32'(done_seen), 32'(frames_exp));

        pulse_ack();
        check_output("ready_after_ack", 32'(bus_rev.o_ready), 32'd1);

        // Frame with valid gaps, acknowledged in the first full cycle.
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b1);
        frames_exp++;
        pulse_ack();
        check_output("ready_after_early_ack", 32'(bus_rev.o_ready), 32'd1);
        check_output("done_pulses_2", 32'(done_seen), 32'(frames_exp));

        // Acknowledge during loading must not disturb the frame.
        apply_stimulus(0, 1'b0);
        apply_stimulus(1, 1'b0);
        pulse_ack();
        check_output("load_ack_ready", 32'(bus_rev.o_ready), 32'd1);
        check_output("load_ack_count", 32'(bus_rev.o_count), 32'd2);
        for (int i = 2; i < N; i++) apply_stimulus(i, 1'b0);
        frames_exp++;
        pulse_ack();

        // Asynchronous reset after three accepts.
        for (int i = 0; i < 3; i++) apply_stimulus(i, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N - 1; i++) apply_stimulus(i, 1'b0);
        check_output("no_early_done", 32'(done_seen), 32'(frames_exp));
        apply_stimulus(N - 1, 1'b0);
        frames_exp++;
        repeat (2) @(negedge clk);

        check_output("done_pulses_total", 32'(done_seen), 32'(frames_exp));
        check_output("rev_queue_empty", 32'(q_rev.size()), 32'd0);
        check_output("nat_queue_empty", 32'(q_nat.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
